// File: rtl/fp_add_pkg.sv
// Shared widths, FSM encoding and result payload for the FP-add alignment stage.
package fp_add_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 28;
    localparam int unsigned AMT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic              comp;
        logic [EXP_W-1:0]  exp_v;
        logic [MANT_W-1:0] mant;
        logic [MANT_W-1:0] aligned;
    } align_result_t;

endpackage

// File: rtl/sticky_rshift.sv
// Right shift by 0..8 with every shifted-out bit OR-merged into bit 0.
module sticky_rshift
    import fp_add_pkg::*;
(
    input  logic [MANT_W-1:0] data_i,
    input  logic [AMT_W-1:0]  amt_i,
    output logic [MANT_W-1:0] data_c_o
);

    logic [MANT_W-1:0] lost_mask;
    logic              lost;

    always_comb begin
        lost_mask = (MANT_W'(1) << amt_i) - MANT_W'(1);
        lost      = |(data_i & lost_mask);
        data_c_o  = data_i >> amt_i;
        data_c_o[0] = data_c_o[0] | lost | data_i[0];
    end

endmodule

// File: rtl/align_sequencer.sv
// Exponent compare and multi-cycle sticky alignment of the smaller mantissa.
module align_sequencer
    import fp_add_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_A,
    input  logic [EXP_W-1:0]  exp_B,
    input  logic [MANT_W-1:0] mantis_A,
    input  logic [MANT_W-1:0] mantis_B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              comp_code,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mantis_out,
    output logic [MANT_W-1:0] mantis_aligned
);

    localparam logic [EXP_W-1:0] STEP_E    = EXP_W'(SHIFT_STEP);
    localparam logic [EXP_W-1:0] FLUSH_LIM = EXP_W'(MANT_W);

    state_e            state_q, state_d;
    logic [EXP_W-1:0]  rem_q, rem_d;
    align_result_t     res_q, res_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic              a_ge_b;
    logic [EXP_W-1:0]  diff;
    logic [MANT_W-1:0] small_mant;
    logic [AMT_W-1:0]  amt;
    logic [MANT_W-1:0] shifted_c;

    // Operand compare; ties favour A.
    always_comb begin
        a_ge_b     = (exp_A >= exp_B);
        diff       = a_ge_b ? (exp_A - exp_B) : (exp_B - exp_A);
        small_mant = a_ge_b ? mantis_B : mantis_A;
        amt        = (rem_q < STEP_E) ? AMT_W'(rem_q) : AMT_W'(STEP_E);
    end

    sticky_rshift u_sticky_rshift (
        .data_i   (res_q.aligned),
        .amt_i    (amt),
        .data_c_o (shifted_c)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    res_d.comp    = a_ge_b;
                    res_d.exp_v   = a_ge_b ? exp_A : exp_B;
                    res_d.mant    = a_ge_b ? mantis_A : mantis_B;
                    res_d.aligned = small_mant;
                    rem_d         = diff;
                    if (diff == '0) begin
                        state_d = DONE;
                    end else if (diff >= FLUSH_LIM) begin
                        // Everything shifts out: only the sticky survives.
                        res_d.aligned = {{(MANT_W-1){1'b0}}, |small_mant};
                        state_d       = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                res_d.aligned = shifted_c;
                rem_d         = rem_q - EXP_W'(amt);
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign comp_code      = res_q.comp;
    assign exp_out        = res_q.exp_v;
    assign mantis_out     = res_q.mant;
    assign mantis_aligned = res_q.aligned;

endmodule

// File: doc/align_sequencer.md
ALIGN_SEQUENCER -- requirements
Module: align_sequencer

Interface
REQ-001 Parameter SHIFT_STEP, default 4: maximum right-shift bits applied per SHIFT cycle; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair on exp_A/exp_B/mantis_A/mantis_B is valid.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 exp_A, exp_B  input  8 each  biased exponents of operands A and B.
REQ-007 mantis_A, mantis_B  input  28 each  extended mantissas (hidden, guard, round, sticky bits included).
REQ-008 out_valid  output  1  aligned result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 comp_code  output  1  1 when exp_A >= exp_B (A is the larger operand), else 0.
REQ-011 exp_out  output  8  larger exponent.
REQ-012 mantis_out  output  28  mantissa of larger operand, unshifted.
REQ-013 mantis_aligned  output  28  mantissa of smaller operand shifted right by the exponent difference, bit 0 sticky.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE with in_valid=1: latch comp_code, exp_out, mantis_out, mantis_aligned (unshifted smaller mantissa), remaining = larger exponent - smaller exponent (8-bit unsigned, never negative).
REQ-016 Equal exponents SHALL select A as larger (comp_code=1).
REQ-017 At acceptance, remaining=0 SHALL go to DONE; remaining>=28 SHALL go to DONE with mantis_aligned = {27'b0, OR of all 28 smaller-mantissa bits}; otherwise go to SHIFT.
REQ-018 Each SHIFT cycle: amt = min(remaining, SHIFT_STEP); mantis_aligned shifted right by amt; new bit 0 = OR of the bits shifted out and the old bit 0; remaining -= amt.
REQ-019 SHIFT SHALL go to DONE in the cycle remaining reaches 0; SHIFT occupancy = ceil(diff / SHIFT_STEP) cycles.
REQ-020 Latency accept-to-out_valid: 1 cycle for diff=0 or diff>=28, else 1 + ceil(diff/SHIFT_STEP) cycles.
REQ-021 In DONE all outputs SHALL stay stable while out_ready=0; out_ready=1 SHALL return to IDLE the next cycle.
REQ-022 No input is accepted in SHIFT or DONE; input changes there SHALL have no effect.
REQ-023 Only the exponent difference, comparison and alignment are performed; no normalisation, rounding or special-value handling.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, in_ready=1 (after reset release), out_valid=0, comp_code=0, exp_out=0, mantis_out=0, mantis_aligned=0, remaining=0.
REQ-025 Reset asserted during SHIFT or DONE SHALL discard the in-flight operation; no out_valid follows.
REQ-026 Reset SHALL be released synchronously to clk by the environment; block adds no synchronizer.

Structure
REQ-027 Shared package fp_add_pkg SHALL hold EXP_W=8, MANT_W=28 and the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
REQ-028 One combinational sub-module sticky_rshift (data 28, amt 0..8 -> shifted data with sticky-merged bit 0) SHALL implement REQ-018.
REQ-029 FSM, remaining counter and output registers SHALL reside in align_sequencer; outputs SHALL be registered.

Verification
REQ-030 exp_A=130, exp_B=130, mantis_A=28'h8000000, mantis_B=28'hC000000 -> out_valid after 1 cycle, comp_code=1, exp_out=130, mantis_aligned=28'hC000000.
REQ-031 exp_A=127, exp_B=137, mantis_A=28'h8000003, STEP=4 -> 3 SHIFT cycles, out_valid at cycle 4, comp_code=0, exp_out=137, mantis_aligned=28'h0020001.
REQ-032 exp_A=200, exp_B=100, mantis_B=28'h0000001 -> out_valid after 1 cycle, mantis_aligned=28'h0000001; mantis_B=0 -> mantis_aligned=0.
REQ-033 out_ready held 0 for 5 cycles in DONE -> outputs constant, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
REQ-034 rst_n pulsed low mid-SHIFT (diff=20) -> out_valid stays 0, all outputs 0, next operand processed normally.
REQ-035 Back-to-back in_valid with out_ready tied 1, diffs 0..27 random -> every result matches reference model, latency per REQ-020.
